// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : instruction fetch stage with bus handshake, hold buffer,
//              delay-slot branch redirect and exception flush.   Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          EXC_CODE_WIDTH = 5,
    parameter int          EC_NONE        = 0,
    parameter int          EC_ADEL        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [5:0]                stall,
    input  logic                      flush,
    input  logic [31:0]               new_pc,
    input  logic                      branch_flag,
    input  logic [31:0]               branch_target,
    output logic                      ibus_req,
    output logic [31:0]               ibus_addr,
    input  logic                      ibus_ack,
    input  logic [31:0]               ibus_rdata,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_inst,
    output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
    output logic                      stallreq_if
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [EXC_CODE_WIDTH-1:0] EXC_NONE = EXC_CODE_WIDTH'(EC_NONE);
    localparam logic [EXC_CODE_WIDTH-1:0] EXC_ADEL = EXC_CODE_WIDTH'(EC_ADEL);

    logic [1:0]                state, state_nxt;
    logic [31:0]               pc, pc_nxt;
    logic                      br_pend, br_pend_nxt;
    logic [31:0]               br_tgt, br_tgt_nxt;
    logic [31:0]               buf_inst, buf_inst_nxt;
    logic [EXC_CODE_WIDTH-1:0] buf_exc, buf_exc_nxt;

    logic misaligned;
    logic complete;
    logic adv;
    logic unused_stall;

    assign misaligned   = (pc[1:0] != 2'b00);
    assign complete     = ((state == S_FETCH) && (ibus_ack || misaligned)) || (state == S_HOLD);
    assign adv          = complete && !stall[0] && !stall[1];
    assign unused_stall = ^stall[5:2];
    assign ibus_addr    = pc;
    assign if_pc        = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            br_pend  <= 1'b0;
            br_tgt   <= 32'h0;
            buf_inst <= 32'h0;
            buf_exc  <= EXC_NONE;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            br_pend  <= br_pend_nxt;
            br_tgt   <= br_tgt_nxt;
            buf_inst <= buf_inst_nxt;
            buf_exc  <= buf_exc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        br_pend_nxt  = br_pend;
        br_tgt_nxt   = br_tgt;
        buf_inst_nxt = buf_inst;
        buf_exc_nxt  = buf_exc;
        if (flush) begin
            state_nxt    = S_FETCH;
            pc_nxt       = new_pc;
            br_pend_nxt  = 1'b0;
            buf_inst_nxt = 32'h0;
            buf_exc_nxt  = EXC_NONE;
        end else begin
            if (branch_flag) begin
                br_pend_nxt = 1'b1;
                br_tgt_nxt  = branch_target;
            end
            case (state)
                S_IDLE: state_nxt = S_FETCH;
                S_FETCH, S_HOLD: begin
                    if (adv) begin
                        // A branch arriving with the delay slot's advance redirects immediately.
                        state_nxt   = S_FETCH;
                        pc_nxt      = branch_flag ? branch_target :
                                      (br_pend ? br_tgt : pc + 32'd4);
                        br_pend_nxt = 1'b0;
                    end else if (complete && (state == S_FETCH)) begin
                        state_nxt    = S_HOLD;
                        buf_inst_nxt = if_inst;
                        buf_exc_nxt  = exc_code_o;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ibus_req    = (state == S_FETCH) && !misaligned && !flush;
        stallreq_if = (state == S_FETCH) && !complete && !flush;
        if_inst     = 32'h0;
        exc_code_o  = EXC_NONE;
        if (!flush && complete) begin
            if (state == S_HOLD) begin
                if_inst    = buf_inst;
                exc_code_o = buf_exc;
            end else if (misaligned) begin
                exc_code_o = EXC_ADEL;
            end else begin
                if_inst = ibus_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter EXC_CODE_WIDTH, default 5, meaning the exception code width.
REQ-003 SHALL have parameter EC_NONE, default 0, meaning no exception; parameter EC_ADEL, default 4, meaning fetch address error.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF/ID, 1 = stop.
REQ-008 flush  in  1  exception flush; redirect to new_pc.
REQ-009 new_pc  in  32  exception/eret target.
REQ-010 branch_flag  in  1  taken branch resolved in ID (1-cycle pulse).
REQ-011 branch_target  in  32  branch destination.
REQ-012 ibus_req  out  1  instruction fetch request (level).
REQ-013 ibus_addr  out  32  fetch address.
REQ-014 ibus_ack  in  1  data valid this cycle; only meaningful while ibus_req = 1.
REQ-015 ibus_rdata  in  32  fetched word.
REQ-016 if_pc  out  32  PC presented to IF/ID.
REQ-017 if_inst  out  32  instruction presented to IF/ID.
REQ-018 exc_code_o  out  EXC_CODE_WIDTH  fetch exception code for IF/ID.
REQ-019 stallreq_if  out  1  IF-stage stall request to pipeline control.

Function
REQ-020 FSM states SHALL be IDLE, FETCH and HOLD; reset enters IDLE; IDLE -> FETCH unconditionally on the next edge.
REQ-021 ibus_addr SHALL equal the pc register at all times.
REQ-022 ibus_req SHALL be 1 only in FETCH with pc[1:0] = 0 and flush = 0.
REQ-023 "complete" SHALL be defined as any one of:
- FETCH with ibus_ack = 1;
- FETCH with pc[1:0] != 0;
- state HOLD.
REQ-024 When complete: if_pc = pc; if_inst = ibus_rdata on ack, 0 when misaligned, buf in HOLD; exc_code_o = EC_ADEL when misaligned, else the value held with buf.
REQ-025 When not complete: if_pc = pc, if_inst = 0, exc_code_o = EC_NONE.
REQ-026 stallreq_if SHALL be 1 exactly when state = FETCH, the fetch is not complete and flush = 0.
REQ-027 adv SHALL be defined as complete and stall[0] = 0 and stall[1] = 0; on adv the next state SHALL be FETCH.
REQ-028 On adv, the next pc SHALL be br_pend ? br_tgt : pc + 4, modulo 2^32 with wrap from 32'hFFFF_FFFC to 0.
REQ-029 On adv, br_pend SHALL clear.
REQ-030 If FETCH completes while stall[0] or stall[1] is 1: capture if_inst/exc_code_o into buf, go to HOLD, keep pc; zero latency loss when the stall releases.
REQ-031 HOLD SHALL issue no bus request and SHALL hold until adv.
REQ-032 branch_flag = 1 SHALL set br_pend = 1 and br_tgt = branch_target (the current fetch is the delay slot); a simultaneous adv SHALL use branch_target directly and leave br_pend = 0.
REQ-033 flush = 1 SHALL have top priority, regardless of stall, state or branch: next pc = new_pc, state = FETCH, br_pend = 0, buf discarded.
REQ-034 An ack coinciding with flush SHALL be ignored, and the request is cancelled.
REQ-035 In the flush cycle, outputs SHALL be if_inst = 0 and exc_code_o = EC_NONE.
REQ-036 No combinational path SHALL exist from stall to ibus_req.

Reset
REQ-037 While rst_n = 0: pc = RESET_PC, state = IDLE, br_pend = 0, br_tgt = 0, buf = 0, ibus_req = 0, if_inst = 0, exc_code_o = EC_NONE, stallreq_if = 0, if_pc = RESET_PC.
REQ-038 Reset asserted mid-fetch SHALL drop ibus_req immediately (asynchronously); a later ack SHALL be ignored.

Verification
REQ-039 Reset release with ack tied 1 and stall 0 -> ibus_addr 0, 4, 8 on consecutive cycles after one IDLE cycle; if_inst tracks rdata.
REQ-040 ack delayed 3 cycles at pc 0x10 -> stallreq_if = 1 for 3 cycles, pc holds 0x10, then advances to 0x14.
REQ-041 ack at pc 0x20 with stall = 6'b000011 for 2 cycles -> HOLD, if_inst = captured word, no req; then pc 0x24 after release.
REQ-042 branch_flag with target 0x100 during a pending fetch at 0x30 -> 0x30 completes, next ibus_addr = 0x100.
REQ-043 flush with new_pc 0x180 during HOLD plus pending branch -> next pc 0x180, br_pend cleared.
REQ-044 new_pc 0x182 -> no ibus_req, exc_code_o = EC_ADEL, if_inst = 0, pc advances to 0x186 when unstalled.
